unidade_busca: RTL and testbench
================================

Name: unidade_busca

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and runs a request/valid handshake with instruction memory.
- Latches the fetched word into an instruction register and presents its 3-bit Opcode to the control unit.
- Applies the control unit's EscPC/Beqz/Ji decisions to choose the next PC: sequential, branch, jump, or halt.

Parameters:
LARG_INSTR, 16, instruction word width; Opcode = instr[LARG_INSTR-1:LARG_INSTR-3]
LARG_PC, 8, PC / instruction-memory address width
PC_INICIAL, 0, PC value loaded at reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_req  output  1  instruction-memory read request
mem_addr  output  LARG_PC  read address; always equals pc
mem_rdata  input  LARG_INSTR  read data, sampled when mem_valid=1
mem_valid  input  1  memory returns data this cycle
Opcode  output  3  instr register top 3 bits, to control unit
instr  output  LARG_INSTR  instruction register
instr_valid  output  1  instr is being decoded this cycle
EscPC  input  1  from control unit; 0 = halt
Beqz  input  1  from control unit; conditional branch
Ji  input  1  from control unit; unconditional jump
zero  input  1  ULA/register zero flag for Beqz
pc  output  LARG_PC  current PC
parado  output  1  processor halted
n_instr  output  16  retired-instruction counter, saturating

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- While rst_n=0:
  - state=OCIOSO, pc=PC_INICIAL, instr=0.
  - mem_req=0, instr_valid=0, parado=0, n_instr=0.
- States:
  - OCIOSO -> BUSCA unconditionally on the first edge after reset release.
  - BUSCA: mem_req=1, mem_addr=pc held stable.
    - On an edge with mem_valid=1: instr<=mem_rdata, go to DECOD.
    - Otherwise stay in BUSCA; any number of wait cycles is allowed.
  - DECOD: instr_valid=1 and mem_req=0 for exactly one cycle. Control inputs are sampled on the closing edge:
    - EscPC=0: pc unchanged, go to PARADO. Halt has priority over Ji/Beqz.
    - Ji=1: pc<=instr[LARG_PC-1:0] (jump target), go to BUSCA. Ji has priority over Beqz.
    - Beqz=1 and zero=1: pc<=pc+1+sext(instr[6:0]), go to BUSCA.
    - Otherwise (including Beqz=1, zero=0): pc<=pc+1, go to BUSCA.
    - Every DECOD exit except halt increments n_instr.
  - PARADO: parado=1, mem_req=0, instr_valid=0. Held until rst_n=0; mem_valid is ignored.
- Arithmetic:
  - PC arithmetic is modulo 2^LARG_PC; wrap-around is silent. pc=255 sequential gives 0; pc=2 with offset -4 gives 255.
  - The offset is 7-bit two's complement, sign-extended to LARG_PC.
- Counter: n_instr saturates at 16'hFFFF and never wraps.
- mem_valid outside BUSCA is ignored; it never updates instr.
- Latency:
  - mem_valid sampled at edge N gives instr_valid=1 in cycle N..N+1.
  - Minimum instruction period is 2 cycles: BUSCA with immediate valid, then DECOD.
- Outputs are registered or pure decodes of state/instr. Opcode is valid whenever instr_valid=1 and is otherwise don't-care, but held stable.
- Reset mid-operation, including during BUSCA with a pending request: everything returns to reset values immediately. A late mem_valid after reset is ignored until BUSCA.

Test Plan:
- Reset then memory with 0 wait states returning opcode 000 at every address, EscPC=1, Beqz=Ji=0 -> pc steps 0,1,2,3 every 2 cycles; n_instr=3 after third DECOD; mem_addr matches pc.
- BUSCA with mem_valid delayed 3 cycles -> mem_req high for 4 cycles, mem_addr stable, instr_valid rises exactly one cycle after mem_valid.
- At pc=10, instr with imm7=7'h7C (-4), Beqz=1: with zero=1 -> next pc=7; repeat with zero=0 -> next pc=11.
- At pc=5, Ji=1 with instr[7:0]=8'h40 and Beqz=1, zero=1 simultaneously -> next pc=0x40 (jump wins).
- Opcode 111 drives EscPC=0 at pc=20 -> parado=1, pc stays 20, mem_req stays 0, n_instr unchanged; pulsing mem_valid changes nothing; rst_n=0 restores pc=0 and parado=0.
- pc=255 sequential -> pc=0. Force n_instr to 16'hFFFF via 65535 instructions (or a preloaded bench) -> stays 16'hFFFF after the next instruction.

Source files
------------

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC, memory handshake, instruction register.
// Applies EscPC/Beqz/Ji from the control unit to pick the next PC.
module unidade_busca #(
  parameter int LARG_INSTR = 16,
  parameter int LARG_PC    = 8,
  parameter logic [LARG_PC-1:0] PC_INICIAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [LARG_PC-1:0]    mem_addr,
  input  logic [LARG_INSTR-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic [2:0]            Opcode,
  output logic [LARG_INSTR-1:0] instr,
  output logic                  instr_valid,
  input  logic                  EscPC,
  input  logic                  Beqz,
  input  logic                  Ji,
  input  logic                  zero,
  output logic [LARG_PC-1:0]    pc,
  output logic                  parado,
  output logic [15:0]           n_instr
);

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    DECOD,
    PARADO
  } estado_t;

  estado_t               estado;
  logic [LARG_INSTR-1:0] ir;
  logic [LARG_PC-1:0]    pc_q;
  logic [15:0]           cnt;

  logic [LARG_PC-1:0] pc_seq;
  logic [LARG_PC-1:0] offset;
  logic [LARG_PC-1:0] pc_desv;
  logic               halt;
  logic               salto;
  logic               desv;
  logic               seq;

  assign pc_seq  = pc_q + LARG_PC'(1);
  assign offset  = {{(LARG_PC-7){ir[6]}}, ir[6:0]};
  assign pc_desv = pc_seq + offset;

  // Mutually exclusive so the decode below is a true one-hot choice.
  assign halt  = !EscPC;
  assign salto = EscPC && Ji;
  assign desv  = EscPC && !Ji && Beqz && zero;
  assign seq   = EscPC && !Ji && !(Beqz && zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      pc_q        <= PC_INICIAL;
      ir          <= '0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      parado      <= 1'b0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          estado  <= BUSCA;
          mem_req <= 1'b1;
        end
        BUSCA: begin
          if (mem_valid) begin
            ir          <= mem_rdata;
            estado      <= DECOD;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        DECOD: begin
          instr_valid <= 1'b0;
          unique case (1'b1)
            halt: begin
              estado <= PARADO;
              parado <= 1'b1;
            end
            salto: begin
              pc_q    <= ir[LARG_PC-1:0];
              estado  <= BUSCA;
              mem_req <= 1'b1;
            end
            desv: begin
              pc_q    <= pc_desv;
              estado  <= BUSCA;
              mem_req <= 1'b1;
            end
            seq: begin
              pc_q    <= pc_seq;
              estado  <= BUSCA;
              mem_req <= 1'b1;
            end
          endcase
          if (!halt && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
        end
        PARADO: begin
          parado <= 1'b1;
        end
      endcase
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = ir;
  assign Opcode   = ir[LARG_INSTR-1 -: 3];
  assign n_instr  = cnt;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: memory responder, tiny control unit,
// transaction-level PC model and directed program walks.
module tb_unidade_busca;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [2:0]  Opcode;
  logic [15:0] instr;
  logic        instr_valid;
  logic        EscPC;
  logic        Beqz;
  logic        Ji;
  logic        zero;
  logic [7:0]  pc;
  logic        parado;
  logic [15:0] n_instr;

  unidade_busca dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .Opcode(Opcode), .instr(instr), .instr_valid(instr_valid),
    .EscPC(EscPC), .Beqz(Beqz), .Ji(Ji), .zero(zero),
    .pc(pc), .parado(parado), .n_instr(n_instr)
  );

  int nchk = 0;
  int nerr = 0;

  logic [15:0] mem [256];
  logic        junk = 0;
  logic        stall = 0;
  logic        nrc = 0;
  logic        resp_v = 0;
  logic [15:0] resp_d = '0;
  logic        z = 1;

  int e_pc = 0;
  int e_cnt = 0;
  bit e_halt = 0;
  logic [15:0] e_instr = '0;

  initial clk = 0;
  always #5 clk = ~clk;

  // Small control unit: 111 halts, 001 beqz, 010 jump, 011 both.
  assign EscPC = (Opcode != 3'b111);
  assign Beqz  = (Opcode == 3'b001) || (Opcode == 3'b011);
  assign Ji    = (Opcode == 3'b010) || (Opcode == 3'b011);
  assign zero  = z;
  assign mem_valid = junk | resp_v;
  assign mem_rdata = junk ? 16'hDEAD : resp_d;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input logic [7:0] a);
    if (a == 8'd64) return 3;
    if (a == 8'd7)  return 1;
    return 0;
  endfunction

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = {3'b000, 13'(i)};
  endtask

  // Memory responder with per-address wait states.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !stall) begin
        if (wcnt == wait_of(mem_addr)) begin
          resp_v = 1;
          resp_d = mem[mem_addr];
          wcnt = 0;
        end else begin
          resp_v = 0;
          wcnt++;
        end
      end else begin
        resp_v = 0;
        wcnt = 0;
      end
    end
  end

  // Per-cycle compare against the fetch model.
  initial begin
    int run;
    int off;
    bit prev_iv;
    run = 0;
    prev_iv = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_pc", int'(pc), 0);
        chk("rst_instr", int'(instr), 0);
        chk("rst_req", int'(mem_req), 0);
        chk("rst_iv", int'(instr_valid), 0);
        chk("rst_parado", int'(parado), 0);
        chk("rst_n_instr", int'(n_instr), 0);
        e_pc = 0; e_cnt = 0; e_halt = 0; e_instr = '0;
        run = 0; prev_iv = 0;
      end else begin
        chk("addr_eq_pc", int'(mem_addr), int'(pc));
        if (e_halt) begin
          chk("halt_parado", int'(parado), 1);
          chk("halt_req", int'(mem_req), 0);
          chk("halt_iv", int'(instr_valid), 0);
          chk("halt_pc", int'(pc), e_pc);
          chk("halt_instr", int'(instr), int'(e_instr));
          chk("halt_n", int'(n_instr), e_cnt);
        end else begin
          chk("parado_low", int'(parado), 0);
          if (mem_req) begin
            chk("req_addr", int'(mem_addr), e_pc);
            chk("req_iv", int'(instr_valid), 0);
            run++;
          end
          if (instr_valid) begin
            chk("iv_one_cycle", int'(prev_iv), 0);
            if (!nrc) chk("req_len", run, wait_of(8'(e_pc)) + 1);
            e_instr = mem[e_pc];
            chk("dec_pc_model", int'(pc), e_pc);
            chk("dec_instr", int'(instr), int'(e_instr));
            chk("dec_opcode", int'(Opcode), int'(e_instr[15:13]));
            chk("dec_n_model", int'(n_instr), e_cnt);
            run = 0;
            if (!EscPC) begin
              e_halt = 1;
            end else begin
              if (Ji) begin
                e_pc = int'(e_instr[7:0]);
              end else if (Beqz && zero) begin
                off = int'(e_instr[6:0]);
                if (off > 63) off = off - 128;
                e_pc = (e_pc + 1 + off) & 255;
              end else begin
                e_pc = (e_pc + 1) & 255;
              end
              if (e_cnt < 65535) e_cnt++;
            end
          end
          prev_iv = instr_valid;
        end
      end
    end
  end

  task automatic expect_decode(input int p, input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (!instr_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("dec_seen", int'(instr_valid), 1);
    chk("dec_pc", int'(pc), p);
    chk("dec_n", int'(n_instr), n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    load_default();
    mem[4]   = 16'h400A;
    mem[10]  = 16'h207C;
    mem[7]   = 16'h400A;
    mem[11]  = 16'h4005;
    mem[5]   = 16'h6040;
    mem[65]  = 16'h40FF;
    mem[255] = 16'h1FFF;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    expect_decode(0, 0);
    expect_decode(1, 1);
    expect_decode(2, 2);
    expect_decode(3, 3);
    expect_decode(4, 4);
    expect_decode(10, 5);
    @(posedge clk); #1 z = 0;
    expect_decode(7, 6);
    expect_decode(10, 7);
    @(posedge clk); #1 z = 1;
    expect_decode(11, 8);
    expect_decode(5, 9);
    expect_decode(64, 10);
    expect_decode(65, 11);
    expect_decode(255, 12);
    expect_decode(0, 13);

    @(posedge clk); #2 rst_n = 0;
    load_default();
    mem[0]  = 16'h4014;
    mem[20] = 16'hF155;
    @(negedge clk); #1 rst_n = 1;
    expect_decode(0, 0);
    expect_decode(20, 1);
    repeat (3) @(negedge clk);
    chk("halt_lit_parado", int'(parado), 1);
    chk("halt_lit_pc", int'(pc), 20);
    chk("halt_lit_n", int'(n_instr), 1);
    chk("halt_lit_req", int'(mem_req), 0);
    junk = 1;
    repeat (3) @(negedge clk);
    junk = 0;
    chk("halt_junk_instr", int'(instr), 16'hF155);
    chk("halt_junk_parado", int'(parado), 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("halt_rst_pc", int'(pc), 0);
    chk("halt_rst_parado", int'(parado), 0);

    load_default();
    nrc = 1;
    stall = 1;
    @(negedge clk); #1 rst_n = 1;
    repeat (4) @(posedge clk);
    chk("pend_req", int'(mem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("pend_rst_req", int'(mem_req), 0);
    chk("pend_rst_pc", int'(pc), 0);
    junk = 1;
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1 junk = 0;
    repeat (3) @(posedge clk);
    #2;
    force dut.cnt = 16'hFFFD;
    e_cnt = 65533;
    #1 release dut.cnt;
    stall = 0;
    expect_decode(0, 16'hFFFD);
    expect_decode(1, 16'hFFFE);
    expect_decode(2, 16'hFFFF);
    expect_decode(3, 16'hFFFF);
    expect_decode(4, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
